conv_patch_loader: RTL and testbench
====================================

# conv_patch_loader

Serial-to-parallel, double-buffered patch packer on the producer side of the convolution unit's flat operand port. Accepts one `DATA_WIDTH` word per handshake from the image/weight fetch stream, assembles `D*S*S` words into the packed vector the convolution unit consumes on its `img`/`fit` inputs, and presents it with a valid/ready handshake. Two patch buffers let the next patch load while the current one is held for the conv unit.

## Interface
- `DATA_WIDTH`, 32, bits per word (IEEE-754 single in the datapath; opaque here)
- `D`, 6, filter depth
- `S`, 5, filter size; patch length `N = D*S*S` words
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `clr` in 1: synchronous flush; drops partial and held patches
- `in_valid` in 1: input word valid
- `in_ready` out 1: loader can accept a word
- `in_data` in `DATA_WIDTH`: input word
- `in_last` in 1: producer marks word N-1 (used only with `CONV_LOADER_LAST_CHECK_EN`)
- `out_valid` out 1: complete patch available
- `out_ready` in 1: conv unit takes the patch
- `out_data` out `N*DATA_WIDTH`: packed patch; word k at bits `[k*DATA_WIDTH +: DATA_WIDTH]`
- `err` out 1: sticky framing error

## Operation
- State: buffers `buf[0..1]` (N words each), `full[1:0]`, `wr_sel`, `rd_sel`, word counter `wcnt` (0..N-1, width `$clog2(N)`).
- Reset: `full=0`, `wr_sel=rd_sel=0`, `wcnt=0`, `err=0`; buffer contents not reset. Outputs at reset: `in_ready=1`, `out_valid=0`, `err=0`, `out_data` undefined.
- `in_ready = ~full[wr_sel]`, from registers only; never depends on `out_ready`.
- Accept (`in_valid & in_ready`): write `in_data` into `buf[wr_sel]` word `wcnt`; if `wcnt==N-1`: set `full[wr_sel]`, toggle `wr_sel`, `wcnt<=0`; else `wcnt<=wcnt+1`.
- `out_valid = full[rd_sel]`; `out_data = buf[rd_sel]`, stable while `out_valid` is high and not taken.
- Take (`out_valid & out_ready`): clear `full[rd_sel]`, toggle `rd_sel`.
- Completion of one buffer and take of the other in the same cycle both take effect.
- Both buffers full: `in_ready=0`; input stalls with no loss.
- `clr`: highest priority; next state equals reset state except contents; `err` also cleared. A simultaneous accept/take is discarded.
- Patches leave in arrival order; no patch skipped or duplicated.

## Timing
- Latency: accept of word N-1 at edge t -> `out_valid=1` after edge t (first visible cycle following).
- Throughput: one word per cycle sustained; N cycles per patch with `out_ready` held high, no bubbles.
- Freed buffer: `in_ready` rises the cycle after the take edge.
- `rst_n` low at any time, mid-patch included: immediate return to reset state; partial patch lost.

## Configuration
- `CONV_LOADER_LAST_CHECK_EN` defined: on accept, `in_last` must equal `(wcnt==N-1)`. On mismatch: `err<=1` (sticky until `clr`/reset); current partial patch discarded (`wcnt<=0`, `full` unchanged, `wr_sel` unchanged). An early `in_last` word is dropped; a missing `in_last` at word N-1 drops that whole patch.
- Not defined: `in_last` ignored, `err` tied 0, no check logic.

## Test plan
(D=6, S=5, N=150, DATA_WIDTH=32)
- Reset, 150 words of 0x40800000 with `out_ready=1` -> `out_valid` one cycle after last accept, all 150 words equal 0x40800000, taken in one cycle.
- Words k=0..149 with value k, `out_ready=0` -> word k at bits `[32k +: 32]`; 150 more words load; then `in_ready=0` with 300 accepted; raising `out_ready` yields patch 0 then patch 1, `in_ready` returns one cycle after first take.
- Continuous stream of 3 patches, `out_ready=1` -> 450 accepts in 450 consecutive cycles, 3 takes, order preserved.
- `clr` after 70 words, then 150 fresh words -> one patch out, containing only fresh words; `rst_n` pulsed low mid-patch gives the same result.
- With macro: `in_last` asserted on word 99 -> `err=1`, first 100 words dropped, next correctly framed patch delivered intact; without macro, same stimulus -> patch delivered at word 150, `err=0`.

Source files
------------

// File: rtl/conv_patch_loader.sv
// Double-buffered serial-to-parallel packer: assembles D*S*S words into one flat patch for the conv unit.
// Optional framing check on in_last is enabled by defining CONV_LOADER_LAST_CHECK_EN.
module conv_patch_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int D          = 6,
    parameter int S          = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [D*S*S*DATA_WIDTH-1:0]  out_data,
    output logic                         err
);

    localparam int N  = D * S * S;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    logic [1:0][N-1:0][DATA_WIDTH-1:0] buf_q;
    logic [1:0]    full_q, full_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          accept, take, at_last, frame_ok;

    assign in_ready  = ~full_q[wr_sel_q];
    assign out_valid = full_q[rd_sel_q];
    assign out_data  = buf_q[rd_sel_q];
    assign accept    = in_valid & in_ready;
    assign take      = out_valid & out_ready;
    assign at_last   = (wcnt_q == LAST_IDX);

`ifdef CONV_LOADER_LAST_CHECK_EN
    logic err_q, err_d;

    // A word is correctly framed when in_last marks exactly the final slot.
    assign frame_ok = (in_last == at_last);
    assign err      = err_q;

    always_comb begin
        err_d = err_q;
        if (clr)
            err_d = 1'b0;
        else if (accept && !frame_ok)
            err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end
`else
    logic unused_in_last;

    assign unused_in_last = in_last;
    assign frame_ok       = 1'b1;
    assign err            = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        wcnt_d   = wcnt_q;
        if (clr) begin
            full_d   = '0;
            wr_sel_d = 1'b0;
            rd_sel_d = 1'b0;
            wcnt_d   = '0;
        end else begin
            if (accept) begin
                if (!frame_ok) begin
                    wcnt_d = '0;
                end else if (at_last) begin
                    full_d[wr_sel_q] = 1'b1;
                    wr_sel_d         = ~wr_sel_q;
                    wcnt_d           = '0;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            // Completion and take always address different buffers, so both updates can coexist.
            if (take) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = ~rd_sel_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // NOTE: patch storage is deliberately left out of reset; the full flags alone qualify its contents.
    always_ff @(posedge clk) begin
        if (accept && !clr)
            buf_q[wr_sel_q][wcnt_q] <= in_data;
    end

endmodule

// File: tb/tb_conv_patch_loader.sv
// Directed self-checking bench for conv_patch_loader (D=6, S=5, N=150, 32-bit words).
// Honours CONV_LOADER_LAST_CHECK_EN to select the expected framing behaviour.
module tb_conv_patch_loader;

    localparam int DW = 32;
    localparam int D  = 6;
    localparam int S  = 5;
    localparam int N  = D * S * S;
    localparam int WN = N * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, err;
    logic [WN-1:0] out_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc = 0;
    logic [WN-1:0] rx_q[$];

    typedef struct {
        logic [31:0] base;
        logic [31:0] inc;
    } vec_t;

    vec_t vecs[4];

    conv_patch_loader #(.DATA_WIDTH(DW), .D(D), .S(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (rst_n && !clr && in_valid && in_ready)
            acc++;
        if (rst_n && !clr && out_valid && out_ready)
            rx_q.push_back(out_data);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WN-1:0] mk(input logic [31:0] base, input logic [31:0] inc);
        logic [WN-1:0] v;
        for (int k = 0; k < N; k++)
            v[k*DW +: DW] = base + inc * 32'(k);
        return v;
    endfunction

    task automatic check_patch(input string name, input logic [WN-1:0] act, input logic [WN-1:0] exp);
        int bad = 0;
        for (int k = 0; k < N; k++)
            if (act[k*DW +: DW] !== exp[k*DW +: DW])
                bad++;
        check(name, 32'(bad), 32'd0);
    endtask

    task automatic expect_rx(input string name, input logic [WN-1:0] exp);
        check({name, "_present"}, 32'(rx_q.size() > 0), 32'd1);
        if (rx_q.size() > 0)
            check_patch(name, rx_q.pop_front(), exp);
    endtask

    // Offers one word and returns #1 after the edge that accepted it.
    task automatic send(input logic [31:0] d, input logic l);
        int w = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        if (!in_ready)
            check("send_in_ready_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_patch(input logic [31:0] base, input logic [31:0] inc);
        for (int k = 0; k < N; k++)
            send(base + inc * 32'(k), k == N - 1);
    endtask

    initial begin
        logic [WN-1:0] exp_v;
        int n0, c0, a0;

        vecs[0] = '{32'h4080_0000, 32'h0000_0000};
        vecs[1] = '{32'h0000_0000, 32'h0000_0001};
        vecs[2] = '{32'hDEAD_BEEF, 32'h0101_0101};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};

        // Reset state, both while asserted and after release.
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Table: one patch per vector with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n0 = rx_q.size();
            send_patch(vecs[i].base, vecs[i].inc);
            check("tbl_valid_after_last", 32'(out_valid), 32'd1);
            check("tbl_in_ready_other_buf", 32'(in_ready), 32'd1);
            step();
            check("tbl_valid_after_take", 32'(out_valid), 32'd0);
            check("tbl_rx_count", 32'(rx_q.size()), 32'(n0 + 1));
            expect_rx("tbl_patch", mk(vecs[i].base, vecs[i].inc));
        end

        // Backpressure: two patches load, third word stalls, ordered drain.
        out_ready = 1'b0;
        a0 = acc;
        send_patch(32'd0, 32'd1);
        check("bp_valid_p0", 32'(out_valid), 32'd1);
        check_patch("bp_layout_p0", out_data, mk(32'd0, 32'd1));
        send_patch(32'd1000, 32'd1);
        check("bp_in_ready_both_full", 32'(in_ready), 32'd0);
        check("bp_accepted_300", 32'(acc - a0), 32'd300);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_0000;
        repeat (3) step();
        check("bp_no_accept_while_full", 32'(acc - a0), 32'd300);
        check_patch("bp_held_stable", out_data, mk(32'd0, 32'd1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_in_ready_before_take", 32'(in_ready), 32'd0);
        step();
        check("bp_in_ready_after_take", 32'(in_ready), 32'd1);
        check("bp_valid_p1", 32'(out_valid), 32'd1);
        check_patch("bp_out_p1", out_data, mk(32'd1000, 32'd1));
        step();
        check("bp_drained", 32'(out_valid), 32'd0);
        expect_rx("bp_rx_p0", mk(32'd0, 32'd1));
        expect_rx("bp_rx_p1", mk(32'd1000, 32'd1));

        // Completion of one buffer on the same edge as the take of the other.
        out_ready = 1'b0;
        send_patch(32'd5000, 32'd1);
        for (int k = 0; k < N - 1; k++)
            send(32'd6000 + 32'(k), 1'b0);
        out_ready = 1'b1;
        send(32'd6000 + 32'(N - 1), 1'b1);
        check("sim_valid_second", 32'(out_valid), 32'd1);
        check("sim_rx_count", 32'(rx_q.size()), 32'd1);
        check_patch("sim_out_second", out_data, mk(32'd6000, 32'd1));
        step();
        check("sim_drained", 32'(out_valid), 32'd0);
        expect_rx("sim_rx_first", mk(32'd5000, 32'd1));
        expect_rx("sim_rx_second", mk(32'd6000, 32'd1));

        // Continuous stream of three patches: one word per cycle, no bubbles.
        c0 = cyc;
        a0 = acc;
        for (int p = 0; p < 3; p++)
            send_patch(32'h0001_0000 * 32'(p + 1), 32'd3);
        check("stream_cycles", 32'(cyc - c0), 32'd450);
        check("stream_accepts", 32'(acc - a0), 32'd450);
        step();
        check("stream_takes", 32'(rx_q.size()), 32'd3);
        for (int p = 0; p < 3; p++)
            expect_rx("stream_order", mk(32'h0001_0000 * 32'(p + 1), 32'd3));

        // clr with one held patch and a 70-word partial.
        out_ready = 1'b0;
        send_patch(32'd7000, 32'd1);
        for (int k = 0; k < 70; k++)
            send(32'hBAD0_0000 + 32'(k), 1'b0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send_patch(32'd8000, 32'd1);
        step();
        check("clr_rx_count", 32'(rx_q.size()), 32'd1);
        expect_rx("clr_fresh", mk(32'd8000, 32'd1));

        // Asynchronous reset mid-patch with a held patch.
        out_ready = 1'b0;
        send_patch(32'd9000, 32'd1);
        for (int k = 0; k < 70; k++)
            send(32'hBAD1_0000 + 32'(k), 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid_async", 32'(out_valid), 32'd0);
        check("arst_in_ready_async", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        send_patch(32'd9500, 32'd1);
        step();
        check("arst_rx_count", 32'(rx_q.size()), 32'd1);
        expect_rx("arst_fresh", mk(32'd9500, 32'd1));

        // Framing: in_last on word 99, then a correctly framed patch.
        for (int k = 0; k < 100; k++)
            send(32'h000A_0000 + 32'(k), k == 99);
`ifdef CONV_LOADER_LAST_CHECK_EN
        check("last_err_set", 32'(err), 32'd1);
`else
        check("last_err_zero", 32'(err), 32'd0);
`endif
        check("last_no_early_patch", 32'(out_valid), 32'd0);
        for (int k = 0; k < N; k++)
            send(32'h000B_0000 + 32'(k), k == N - 1);
        step();
        check("last_rx_count", 32'(rx_q.size()), 32'd1);
`ifdef CONV_LOADER_LAST_CHECK_EN
        expect_rx("last_framed_patch", mk(32'h000B_0000, 32'd1));
        check("last_err_sticky", 32'(err), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("last_err_cleared", 32'(err), 32'd0);
`else
        for (int k = 0; k < N; k++)
            exp_v[k*DW +: DW] = (k < 100) ? 32'h000A_0000 + 32'(k) : 32'h000B_0000 + 32'(k - 100);
        expect_rx("last_ignored_patch", exp_v);
        check("last_err_still_zero", 32'(err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
